// File: rtl/color_bounce_drawer.sv
// -----------------------------------------------------------------------------
// color_bounce_drawer
//
// Purpose:
//   Turns one tick of ball/platform state into a serial stream of single-pixel
//   writes for a 160x120 VGA adapter. A frame is three passes, one pixel slot
//   per clock:
//     1. ERASE : ball square at its previous row, painted in BG_COLOUR
//     2. PLATS : the four platforms (0..3) in their current colours
//     3. BALL  : ball square at its new row in its new colour
//   followed by a single FIN cycle that pulses done.
//
// Ports:
//   clk            in   system clock
//   resetn         in   synchronous, active-low reset
//   start          in   one-cycle frame request (accepted in IDLE or FIN)
//   prev_ball[7:0] in   ball top row before the update
//   curr_ball[7:0] in   ball top row after the update
//   color_ball[2:0]in   ball colour
//   position_plats[27:0] in  platform i top row = bits [7i+6:7i]
//   color_plats[11:0]    in  platform i colour  = bits [3i+2:3i]
//   x[7:0]         out  pixel column
//   y[6:0]         out  pixel row (low 7 bits of the 9-bit row sum)
//   colour[2:0]    out  pixel colour
//   plot           out  pixel write enable (0 when the row is clipped)
//   busy           out  high for every pixel slot of a frame
//   done           out  one-cycle pulse in the FIN cycle
// -----------------------------------------------------------------------------
module color_bounce_drawer #(
    parameter int       BALL_X     = 76,
    parameter int       BALL_SIZE  = 4,
    parameter int       PLAT_X0    = 8,
    parameter int       PLAT_PITCH = 40,
    parameter int       PLAT_W     = 16,
    parameter int       PLAT_H     = 2,
    parameter int       SCREEN_H   = 120,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  prev_ball,
    input  logic [7:0]  curr_ball,
    input  logic [2:0]  color_ball,
    input  logic [27:0] position_plats,
    input  logic [11:0] color_plats,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam int NUM_PLATS = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_PLATS,
        S_BALL,
        S_FIN
    } state_t;

    // -------------------------------------------------------------------------
    // State, counters and latched frame inputs
    // -------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_dx;
    logic [7:0]  r_dy;
    logic [1:0]  r_pi;
    logic [7:0]  w_dx_next;
    logic [7:0]  w_dy_next;
    logic [1:0]  w_pi_next;

    logic [7:0]  r_prev_ball;
    logic [7:0]  r_curr_ball;
    logic [2:0]  r_color_ball;
    logic [27:0] r_position_plats;
    logic [11:0] r_color_plats;

    // Registered pixel outputs
    logic [7:0]  r_x;
    logic [6:0]  r_y;
    logic [2:0]  r_colour;
    logic        r_plot;
    logic        r_busy;
    logic        r_done;

    logic [7:0]  w_x_next;
    logic [6:0]  w_y_next;
    logic [2:0]  w_colour_next;
    logic        w_plot_next;
    logic [8:0]  w_row_sum;
    logic        w_drawing;

    // -------------------------------------------------------------------------
    // Frame source selection.
    // The pixel for slot 0 is registered on the accepting edge itself, before
    // the input latches have been loaded, so on that edge the live inputs feed
    // the pixel generator directly. Afterwards only the latched copy is used,
    // which is what makes later input changes invisible to the frame.
    // -------------------------------------------------------------------------
    logic        w_accept;
    logic [7:0]  w_src_prev;
    logic [7:0]  w_src_curr;
    logic [2:0]  w_src_cball;
    logic [27:0] w_src_pos;
    logic [11:0] w_src_cplats;

    assign w_accept     = start && ((r_state == S_IDLE) || (r_state == S_FIN));
    assign w_src_prev   = w_accept ? prev_ball      : r_prev_ball;
    assign w_src_curr   = w_accept ? curr_ball      : r_curr_ball;
    assign w_src_cball  = w_accept ? color_ball     : r_color_ball;
    assign w_src_pos    = w_accept ? position_plats : r_position_plats;
    assign w_src_cplats = w_accept ? color_plats    : r_color_plats;

    // Per-platform row, colour and left column
    logic [6:0] w_plat_row [NUM_PLATS];
    logic [2:0] w_plat_col [NUM_PLATS];
    logic [7:0] w_plat_x0  [NUM_PLATS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLATS; gi++) begin : g_plat
            assign w_plat_row[gi] = w_src_pos[7*gi +: 7];
            assign w_plat_col[gi] = w_src_cplats[3*gi +: 3];
            assign w_plat_x0[gi]  = 8'(PLAT_X0 + gi * PLAT_PITCH);
        end
    endgenerate

    // Terminal-count flags for the scan counters
    logic w_ball_dx_last;
    logic w_ball_dy_last;
    logic w_plat_dx_last;
    logic w_plat_dy_last;
    logic w_plat_i_last;

    assign w_ball_dx_last = (r_dx == 8'(BALL_SIZE - 1));
    assign w_ball_dy_last = (r_dy == 8'(BALL_SIZE - 1));
    assign w_plat_dx_last = (r_dx == 8'(PLAT_W - 1));
    assign w_plat_dy_last = (r_dy == 8'(PLAT_H - 1));
    assign w_plat_i_last  = (r_pi == 2'(NUM_PLATS - 1));

    // -------------------------------------------------------------------------
    // State register, counters, latches and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state          <= S_IDLE;
            r_dx             <= '0;
            r_dy             <= '0;
            r_pi             <= '0;
            r_prev_ball      <= '0;
            r_curr_ball      <= '0;
            r_color_ball     <= '0;
            r_position_plats <= '0;
            r_color_plats    <= '0;
            r_x              <= '0;
            r_y              <= '0;
            r_colour         <= '0;
            r_plot           <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_dx     <= w_dx_next;
            r_dy     <= w_dy_next;
            r_pi     <= w_pi_next;
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_colour <= w_colour_next;
            r_plot   <= w_plot_next;
            r_busy   <= w_drawing;
            r_done   <= (w_state_next == S_FIN);
            if (w_accept) begin
                r_prev_ball      <= prev_ball;
                r_curr_ball      <= curr_ball;
                r_color_ball     <= color_ball;
                r_position_plats <= position_plats;
                r_color_plats    <= color_plats;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and scan-counter logic.
    // The counters always name the slot currently shown on the outputs; this
    // block advances them to the slot that will be shown after the edge.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_dx_next    = r_dx;
        w_dy_next    = r_dy;
        w_pi_next    = r_pi;

        case (r_state)
            S_IDLE, S_FIN: begin
                w_dx_next = '0;
                w_dy_next = '0;
                w_pi_next = '0;
                w_state_next = start ? S_ERASE : S_IDLE;
            end

            S_ERASE, S_BALL: begin
                if (w_ball_dx_last) begin
                    w_dx_next = '0;
                    if (w_ball_dy_last) begin
                        w_dy_next    = '0;
                        w_state_next = (r_state == S_ERASE) ? S_PLATS : S_FIN;
                    end else begin
                        w_dy_next = r_dy + 8'd1;
                    end
                end else begin
                    w_dx_next = r_dx + 8'd1;
                end
            end

            S_PLATS: begin
                if (w_plat_dx_last) begin
                    w_dx_next = '0;
                    if (w_plat_dy_last) begin
                        w_dy_next = '0;
                        if (w_plat_i_last) begin
                            w_pi_next    = '0;
                            w_state_next = S_BALL;
                        end else begin
                            w_pi_next = r_pi + 2'd1;
                        end
                    end else begin
                        w_dy_next = r_dy + 8'd1;
                    end
                end else begin
                    w_dx_next = r_dx + 8'd1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_dx_next    = '0;
                w_dy_next    = '0;
                w_pi_next    = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Pixel generator for the slot that follows the edge.
    // Outside pixel slots x/y/colour hold; plot drops to 0. The row sum is
    // 9 bits so rows past the bottom of the screen are detected rather than
    // wrapping back onto visible rows; such slots still take a cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        w_x_next      = r_x;
        w_y_next      = r_y;
        w_colour_next = r_colour;
        w_plot_next   = 1'b0;
        w_row_sum     = '0;
        w_drawing     = 1'b0;

        case (w_state_next)
            S_ERASE: begin
                w_drawing     = 1'b1;
                w_x_next      = 8'(BALL_X) + w_dx_next;
                w_row_sum     = {1'b0, w_src_prev} + {1'b0, w_dy_next};
                w_colour_next = BG_COLOUR;
            end
            S_PLATS: begin
                w_drawing     = 1'b1;
                w_x_next      = w_plat_x0[w_pi_next] + w_dx_next;
                w_row_sum     = {2'b00, w_plat_row[w_pi_next]} + {1'b0, w_dy_next};
                w_colour_next = w_plat_col[w_pi_next];
            end
            S_BALL: begin
                w_drawing     = 1'b1;
                w_x_next      = 8'(BALL_X) + w_dx_next;
                w_row_sum     = {1'b0, w_src_curr} + {1'b0, w_dy_next};
                w_colour_next = w_src_cball;
            end
            default: begin
                w_drawing = 1'b0;
            end
        endcase

        if (w_drawing) begin
            w_y_next    = w_row_sum[6:0];
            w_plot_next = (w_row_sum < 9'(SCREEN_H));
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_color_bounce_drawer.sv
// -----------------------------------------------------------------------------
// Testbench for color_bounce_drawer.
// A frame-level model expands each accepted start into the list of expected
// per-cycle output records (pixel slots in scan order, then FIN). Every cycle
// the DUT outputs are compared with the head of that list; directed frames add
// literal checks on captured plots and timing.
// -----------------------------------------------------------------------------
module tb_color_bounce_drawer;

    localparam int M_BALL_X   = 76;
    localparam int M_BALL_SZ  = 4;
    localparam int M_PLAT_X0  = 8;
    localparam int M_PITCH    = 40;
    localparam int M_PLAT_W   = 16;
    localparam int M_PLAT_H   = 2;
    localparam int M_SCREEN_H = 120;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [7:0]  prev_ball;
    logic [7:0]  curr_ball;
    logic [2:0]  color_ball;
    logic [27:0] position_plats;
    logic [11:0] color_plats;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    color_bounce_drawer dut (
        .clk            (clk),
        .resetn         (resetn),
        .start          (start),
        .prev_ball      (prev_ball),
        .curr_ball      (curr_ball),
        .color_ball     (color_ball),
        .position_plats (position_plats),
        .color_plats    (color_plats),
        .x              (x),
        .y              (y),
        .colour         (colour),
        .plot           (plot),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       plot;
        logic       busy;
        logic       done;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        cur;
    logic [17:0] cap[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          done_cnt    = 0;
    int          busy_cnt    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_slot(input int xv, input int row, input logic [2:0] c);
        rec_t r;
        r.x    = 8'(xv);
        r.y    = 7'(row);
        r.c    = c;
        r.plot = (row < M_SCREEN_H);
        r.busy = 1'b1;
        r.done = 1'b0;
        exp_q.push_back(r);
    endfunction

    // Expand one frame from the values present on the inputs at acceptance.
    function automatic void build_frame();
        rec_t r;
        for (int dy = 0; dy < M_BALL_SZ; dy++)
            for (int dx = 0; dx < M_BALL_SZ; dx++)
                push_slot(M_BALL_X + dx, int'(prev_ball) + dy, 3'b000);
        for (int p = 0; p < 4; p++)
            for (int dy = 0; dy < M_PLAT_H; dy++)
                for (int dx = 0; dx < M_PLAT_W; dx++)
                    push_slot(M_PLAT_X0 + p * M_PITCH + dx,
                              int'(position_plats[7*p +: 7]) + dy,
                              color_plats[3*p +: 3]);
        for (int dy = 0; dy < M_BALL_SZ; dy++)
            for (int dx = 0; dx < M_BALL_SZ; dx++)
                push_slot(M_BALL_X + dx, int'(curr_ball) + dy, color_ball);
        r      = exp_q[$];
        r.plot = 1'b0;
        r.busy = 1'b0;
        r.done = 1'b1;
        exp_q.push_back(r);
    endfunction

    // One clock: advance the model on the edge, then compare and capture.
    task automatic step();
        @(posedge clk);
        if (!resetn) begin
            exp_q.delete();
            cur = '0;
        end else begin
            if (start && exp_q.size() == 0) build_frame();
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
            end else begin
                cur.plot = 1'b0;
                cur.busy = 1'b0;
                cur.done = 1'b0;
            end
        end
        #1;
        chk("x",      x,      cur.x);
        chk("y",      y,      cur.y);
        chk("colour", colour, cur.c);
        chk("plot",   plot,   cur.plot);
        chk("busy",   busy,   cur.busy);
        chk("done",   done,   cur.done);
        if (plot === 1'b1) cap.push_back({x, y, colour});
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cnt++;
    endtask

    function automatic logic [17:0] getcap(input int i);
        if (i < 0 || i >= cap.size()) return 18'h3ffff;
        return cap[i];
    endfunction

    // Pulse start, run until done (bounded). Optionally re-pulse start at
    // cycle inj, or change the inputs one cycle after the accepting edge.
    task automatic run_frame(input int inj, input bit mutate, output int done_cyc);
        int cyc;
        cap.delete();
        done_cnt = 0;
        busy_cnt = 0;
        done_cyc = -1;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        while (done_cyc < 0) begin
            if (done === 1'b1) begin
                done_cyc = cyc;
            end else if (cyc >= 400) begin
                chk("frame_timeout", cyc, 161);
                done_cyc = 0;
            end else begin
                if (mutate && cyc == 1) begin
                    curr_ball   = curr_ball + 8'd37;
                    color_plats = ~color_plats;
                    color_ball  = ~color_ball;
                end
                start = (cyc == inj);
                step();
                start = 1'b0;
                cyc++;
            end
        end
    endtask

    task automatic set_default_frame();
        prev_ball      = 8'd10;
        curr_ball      = 8'd11;
        color_ball     = 3'b100;
        position_plats = {7'd90, 7'd70, 7'd50, 7'd30};
        color_plats    = {3'd5, 3'd3, 3'd2, 3'd1};
    endtask

    int dc;

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        set_default_frame();
        step();
        step();
        chk("rst_x",    x,    0);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        resetn = 1'b1;
        step();

        // Frame 1: erase / platforms / ball with literal spot checks
        run_frame(-1, 1'b0, dc);
        $display("frame default: done at cycle %0d, %0d plots", dc, cap.size());
        chk("f1_done_cycle", dc, 161);
        chk("f1_busy_cnt",   busy_cnt, 160);
        chk("f1_plots",      cap.size(), 160);
        chk("f1_first",      getcap(0),   {8'd76, 7'd10, 3'd0});
        chk("f1_erase_last", getcap(15),  {8'd79, 7'd13, 3'd0});
        chk("f1_ball_first", getcap(144), {8'd76, 7'd11, 3'd4});
        chk("f1_ball_last",  getcap(159), {8'd79, 7'd14, 3'd4});
        for (int p = 0; p < 4; p++) begin
            chk("plat_start",  getcap(16 + 32*p),      {8'(8 + 40*p), 7'(30 + 20*p), 3'(p == 3 ? 5 : p + 1)});
            chk("plat_row1",   getcap(16 + 32*p + 16), {8'(8 + 40*p), 7'(31 + 20*p), 3'(p == 3 ? 5 : p + 1)});
        end
        chk("plat2_first", getcap(80),  {8'd88,  7'd70, 3'd3});
        chk("plat2_last",  getcap(111), {8'd103, 7'd71, 3'd3});
        done_cnt = 0;
        repeat (3) step();
        chk("f1_no_extra_done", done_cnt, 0);

        // Frame 2: ball clipped at the bottom edge
        curr_ball = 8'd118;
        run_frame(-1, 1'b0, dc);
        $display("frame clip: done at cycle %0d, %0d plots", dc, cap.size());
        chk("clip_done_cycle", dc, 161);
        chk("clip_busy_cnt",   busy_cnt, 160);
        chk("clip_plots",      cap.size(), 152);
        chk("clip_ball_first", getcap(144), {8'd76, 7'd118, 3'd4});
        chk("clip_ball_last",  getcap(151), {8'd79, 7'd119, 3'd4});
        repeat (2) step();

        // Frame 3: start mid-frame ignored; then start in FIN, back to back
        set_default_frame();
        run_frame(50, 1'b0, dc);
        $display("frame mid-start: done at cycle %0d", dc);
        chk("mid_done_cycle", dc, 161);
        chk("mid_done_cnt",   done_cnt, 1);
        run_frame(-1, 1'b0, dc);
        $display("frame back-to-back: done at cycle %0d", dc);
        chk("b2b_done_cycle", dc, 161);
        chk("b2b_first",      getcap(0), {8'd76, 7'd10, 3'd0});
        repeat (2) step();

        // Frame 4: reset at cycle 80 abandons the frame
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (79) step();
        resetn = 1'b0;
        step();
        $display("frame reset at cycle 80");
        chk("mrst_x",      x,      0);
        chk("mrst_y",      y,      0);
        chk("mrst_colour", colour, 0);
        chk("mrst_plot",   plot,   0);
        chk("mrst_busy",   busy,   0);
        chk("mrst_done",   done,   0);
        resetn = 1'b1;
        done_cnt = 0;
        repeat (100) step();
        chk("mrst_no_done", done_cnt, 0);
        run_frame(-1, 1'b0, dc);
        chk("post_rst_done_cycle", dc, 161);
        repeat (2) step();

        // Frame 5: inputs change right after acceptance
        set_default_frame();
        run_frame(-1, 1'b1, dc);
        $display("frame latched inputs: done at cycle %0d", dc);
        chk("latch_plat0",     getcap(16),  {8'd8,  7'd30, 3'd1});
        chk("latch_ball_last", getcap(159), {8'd79, 7'd14, 3'd4});
        repeat (2) step();

        // Randomised frames
        for (int k = 0; k < 20; k++) begin
            int inj;
            prev_ball      = 8'($urandom);
            curr_ball      = 8'($urandom);
            color_ball     = 3'($urandom);
            position_plats = 28'($urandom);
            color_plats    = 12'($urandom);
            inj            = int'($urandom_range(0, 250));
            run_frame(inj, k[0], dc);
            $display("frame rand %0d: prev=%0d curr=%0d done at cycle %0d, %0d plots",
                     k, prev_ball, curr_ball, dc, cap.size());
            chk("rand_done_cycle", dc, 161);
            if ($urandom_range(0, 1) == 0) begin
                repeat (int'($urandom_range(1, 4))) step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
